// File: rtl/div_ctrl_32.sv
// div_ctrl_32 - EX-stage sequencer for the M-extension divide unit.
// Decodes DIV/DIVU/REM/REMU, resolves divide-by-zero and signed overflow
// locally, feeds operand magnitudes to the 32-bit divider core through a
// ce/ready handshake, stalls the pipeline meanwhile and sign-corrects the
// unsigned result.
// Optional feature: define DIV_RESULT_CACHE_EN to keep a one-entry cache of
// the last divider result, so a REM after a DIV (or vice versa) on the same
// operands completes in one cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; accept a valid, unflushed instruction
// WAIT  | divider enabled; wait for ready (ignored in the first cycle)
// DONE  | result_o valid, done_o pulses; back to IDLE
`timescale 1ns/1ps

module div_ctrl_32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        div_ce_o,
  output logic [31:0] div_rs1_o,
  output logic [31:0] div_rs2_o,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i,
  input  logic        div_ready_i
);

  localparam int GPR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 is_signed_in, is_rem_in;
  logic                 neg_q_in, neg_r_in;
  logic [GPR_WIDTH-1:0] mag1_in, mag2_in;
  logic                 div_zero, signed_ovf, special;
  logic [GPR_WIDTH-1:0] special_res;
  logic                 accept, capture;
  logic                 cache_hit;
  logic [GPR_WIDTH-1:0] cache_quot, cache_rem;

  logic                 is_rem_q, neg_q_q, neg_r_q;
  logic                 first_q;

  // Sign-correct an unsigned quotient/remainder pair and pick the one rd wants.
  function automatic logic [GPR_WIDTH-1:0] correct_result(
    input logic                 is_rem,
    input logic                 neg_q,
    input logic                 neg_r,
    input logic [GPR_WIDTH-1:0] quot,
    input logic [GPR_WIDTH-1:0] rem
  );
    if (is_rem) correct_result = neg_r ? -rem : rem;
    else        correct_result = neg_q ? -quot : quot;
  endfunction

  // Decode of the instruction currently presented in EX.
  always_comb begin
    is_signed_in = ~funct3_i[0];
    is_rem_in    = funct3_i[1];
    mag1_in      = (is_signed_in && rs1_i[GPR_WIDTH-1]) ? -rs1_i : rs1_i;
    mag2_in      = (is_signed_in && rs2_i[GPR_WIDTH-1]) ? -rs2_i : rs2_i;
    neg_q_in     = is_signed_in & (rs1_i[GPR_WIDTH-1] ^ rs2_i[GPR_WIDTH-1]);
    neg_r_in     = is_signed_in & rs1_i[GPR_WIDTH-1];
    div_zero     = (rs2_i == '0);
    signed_ovf   = is_signed_in && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    special      = div_zero | signed_ovf;
    if (div_zero) special_res = is_rem_in ? rs1_i : 32'hFFFF_FFFF;
    else          special_res = is_rem_in ? 32'h0 : 32'h8000_0000;
  end

  // Only funct3 encodings 1xx are divide-class; anything else is not taken.
  assign accept  = (state_q == ST_IDLE) && valid_i && funct3_i[2] && !flush_i;
  assign capture = (state_q == ST_WAIT) && !first_q && div_ready_i && !flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic                 cache_vld_q, cache_sgn_q, key_sgn_q;
  logic [GPR_WIDTH-1:0] cache_rs1_q, cache_rs2_q, cache_quot_q, cache_rem_q;
  logic [GPR_WIDTH-1:0] key_rs1_q, key_rs2_q;

  assign cache_hit  = cache_vld_q && !special && (cache_rs1_q == rs1_i) &&
                      (cache_rs2_q == rs2_i) && (cache_sgn_q == is_signed_in);
  assign cache_quot = cache_quot_q;
  assign cache_rem  = cache_rem_q;

  // Remember the key at accept; commit key plus divider data on capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_vld_q  <= 1'b0;
      cache_sgn_q  <= 1'b0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_quot_q <= '0;
      cache_rem_q  <= '0;
      key_sgn_q    <= 1'b0;
      key_rs1_q    <= '0;
      key_rs2_q    <= '0;
    end else begin
      if (accept) begin
        key_sgn_q <= is_signed_in;
        key_rs1_q <= rs1_i;
        key_rs2_q <= rs2_i;
      end
      if (capture) begin
        cache_vld_q  <= 1'b1;
        cache_sgn_q  <= key_sgn_q;
        cache_rs1_q  <= key_rs1_q;
        cache_rs2_q  <= key_rs2_q;
        cache_quot_q <= div_quot_i;
        cache_rem_q  <= div_rem_i;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_quot = '0;
  assign cache_rem  = '0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    div_ce_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = (special || cache_hit) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o  = 1'b1;
        div_ce_o = 1'b1;
        if (!first_q && div_ready_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Operand latch at accept and the registered rd result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      first_q   <= 1'b0;
      div_rs1_o <= '0;
      div_rs2_o <= '0;
      result_o  <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        is_rem_q  <= is_rem_in;
        neg_q_q   <= neg_q_in;
        neg_r_q   <= neg_r_in;
        div_rs1_o <= mag1_in;
        div_rs2_o <= mag2_in;
        if (special)
          result_o <= special_res;
        else if (cache_hit)
          result_o <= correct_result(is_rem_in, neg_q_in, neg_r_in, cache_quot, cache_rem);
      end
      if (capture)
        result_o <= correct_result(is_rem_q, neg_q_q, neg_r_q, div_quot_i, div_rem_i);
    end
  end

endmodule

// File: doc/div_ctrl_32.md
# div_ctrl_32

Initiator-side sequencer for the M-extension divide unit. Sits in the EX stage between the pipeline and the 32-bit divider core. Decodes DIV/DIVU/REM/REMU, handles the signed special cases itself, and converts signed operands to magnitudes. It drives the divider's `ce`/operand/`ready` handshake, stalls the pipeline until the result is back, and applies sign correction.

## Interface
- No parameters. All data widths are `GPR_WIDTH` (32).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous reset, active-high.
- `valid_i` in 1: a divide-class instruction is present in EX.
- `funct3_i` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i`, `rs2_i` in 32: dividend and divisor.
- `flush_i` in 1: kill the in-flight operation.
- `stall_o` out 1: hold the pipeline.
- `done_o` out 1: one-cycle pulse; `result_o` is valid.
- `result_o` out 32: rd write data.
- `div_ce_o` out 1: divider enable.
- `div_rs1_o`, `div_rs2_o` out 32: unsigned operands to the divider.
- `div_quot_i`, `div_rem_i` in 32: divider unsigned quotient and remainder.
- `div_ready_i` in 1: divider result ready.

## Operation
**States:** IDLE, WAIT, DONE.

**IDLE**
- If `valid_i` is high and `flush_i` is low, the instruction is accepted; latch op, signs and magnitudes.
- Signed ops: magnitude = two's-complement negate if bit 31 is set. 0x80000000 maps to 0x80000000 unsigned.
- Unsigned ops: operands pass through unchanged.
- Special cases go straight to DONE; the divider is not enabled:
  - `rs2 == 0`: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> `rs1_i`.
  - DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Otherwise go to WAIT.

**WAIT**
- `div_ce_o` = 1.
- `div_rs1_o`/`div_rs2_o` hold the latched magnitudes, stable for the whole state.
- `div_ready_i` is ignored in the first WAIT cycle, because the divider reports ready while `ce` is low.
- From the second WAIT cycle on, `div_ready_i` high captures `div_quot_i`/`div_rem_i` and moves to DONE.
- `div_ce_o` drops in DONE, giving at least one low cycle between operations.

**DONE**
- `done_o` = 1 and `result_o` is driven; then go to IDLE.
- `valid_i` is ignored in DONE; it still carries the completing instruction.

**Sign correction** (DIV/REM only)
- Quotient is negated if sign(rs1) XOR sign(rs2).
- Remainder is negated if sign(rs1).
- All arithmetic is mod 2^32.

**`stall_o`** = (IDLE && `valid_i` && !`flush_i`) || WAIT. It is 0 in DONE.

**Flush**
- `flush_i` in any state -> IDLE next cycle.
- `div_ce_o` is 0 from the next cycle; no `done_o`; any late divider result is discarded.
- `flush_i` has priority over `div_ready_i` in the same cycle.

**Reset**
- State IDLE.
- `stall_o`, `done_o`, `div_ce_o` = 0; `result_o`, `div_rs1_o`, `div_rs2_o` = 0.
- Cache (if compiled in) is invalidated.
- Reset mid-WAIT abandons the operation.

## Timing
- Special case or cache hit: accept at cycle 0, `done_o` at cycle 1 (latency 1).
- Normal op with a divider that raises ready one cycle after `ce`:
  - cycle 0 accept;
  - cycles 1–2 `div_ce_o` = 1, with `div_ready_i` sampled at cycle 2;
  - `done_o` at cycle 3.
- Slower divider: 1 cycle + WAIT length + 1.
- `result_o` is registered. It holds its value after DONE until the next completion.
- Back-to-back ops: next accept no earlier than the cycle after DONE.

## Configuration
**`DIV_RESULT_CACHE_EN`**
- **Defined:** keep one entry.
  - Key: {`rs1_i`, `rs2_i`, signed/unsigned}.
  - Data: the captured unsigned quotient and remainder.
  - Written on every divider capture that is not flushed; invalidated by reset.
  - In IDLE, a key match on a non-special op goes straight to DONE (latency 1) with sign correction applied. A DIV followed by a REM on the same operands costs 1 cycle.
- **Not defined:** no cache storage; every non-special op goes through WAIT.

## Test plan
- DIV 0xFFFFFFF9 (−7) / 2, divider ready at cycle 2 -> `div_rs1_o` = 7, `div_rs2_o` = 2; `done_o` at cycle 3 with `result_o` 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU 100 / 0 -> `done_o` at cycle 1, `result_o` 0xFFFFFFFF, `div_ce_o` never high. REMU 100 / 0 -> 100.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM of the same operands -> 0.
- Divider ready held low for 10 WAIT cycles -> `stall_o` high throughout and operands stable; `done_o` in the cycle after ready.
- `flush_i` asserted in the second WAIT cycle, together with `div_ready_i` -> no `done_o`; `div_ce_o` 0 the next cycle; state IDLE. The next DIVU 9 / 3 returns 3.
- With `DIV_RESULT_CACHE_EN`: DIVU 17 / 5 (latency 3, result 3), then REMU 17 / 5 -> `done_o` at cycle 1 with result 2 and `div_ce_o` never asserted. After `rst_i`, the same REMU takes latency 3.
